// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encoding and NZCV flag bit positions.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_MUL  = 5'd3,
    OP_MOV  = 5'd4,
    OP_DIV  = 5'd5,
    OP_LNUM = 5'd6,
    OP_SLL  = 5'd7,
    OP_SRL  = 5'd8,
    OP_AND  = 5'd9,
    OP_OR   = 5'd10,
    OP_XOR  = 5'd11,
    OP_NOT  = 5'd12
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational NZCV generation from the opcode, operand signs, the raw
// result and the per-operation carry sources. Unused opcodes yield 0000.
// Optional macro ALU_SHIFT_EN adds the shifter carry input for SLL/SRL.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [4:0]       op,
  input  logic             a_sign,
  input  logic             b_sign,
  input  logic [WIDTH-1:0] res,
  input  logic             add_carry,
  input  logic             sub_no_borrow,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic             div_zero,
`ifdef ALU_SHIFT_EN
  input  logic             shift_c,
`endif
  output logic [3:0]       flags
);

  logic valid;
  logic c_flag;
  logic v_flag;
  logic r_sign;

  assign r_sign = res[WIDTH-1];

  // Select C/V per operation and mask everything for unused opcodes
  always_comb begin
    valid  = 1'b1;
    c_flag = 1'b0;
    v_flag = 1'b0;
    flags  = 4'b0000;
    case (op)
      OP_ADD: begin
        c_flag = add_carry;
        v_flag = (a_sign == b_sign) && (r_sign != a_sign);
      end
      OP_SUB: begin
        c_flag = sub_no_borrow;
        v_flag = (a_sign != b_sign) && (r_sign != a_sign);
      end
      OP_MUL:  c_flag = |mul_hi;
      OP_DIV:  v_flag = div_zero;
      OP_MOV, OP_LNUM, OP_AND, OP_OR, OP_XOR, OP_NOT: ;
`ifdef ALU_SHIFT_EN
      OP_SLL, OP_SRL: c_flag = shift_c;
`endif
      default: valid = 1'b0;
    endcase
    if (valid) begin
      flags[FLAG_N] = r_sign;
      flags[FLAG_Z] = (res == '0);
      flags[FLAG_C] = c_flag;
      flags[FLAG_V] = v_flag;
    end
  end

endmodule

// File: rtl/alu.sv
// Registered-output 32-bit ALU: combinational compute, one-cycle latency,
// a new operation accepted every cycle. Optional macro ALU_SHIFT_EN enables
// SLL (opcode 7) and SRL (opcode 8); otherwise those codes are unused.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       alu_ctrl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags
);

  logic [WIDTH:0]       add_ext;
  logic [WIDTH-1:0]     sub_res;
  logic                 sub_no_borrow;
  logic [2*WIDTH-1:0]   prod;
  logic                 div_zero;
  logic [WIDTH-1:0]     res_p0;
  logic [3:0]           flags_p0;
  logic [WIDTH-1:0]     result_p1;
  logic [3:0]           flags_p1;

  assign add_ext       = {1'b0, srcA} + {1'b0, srcB};
  assign sub_res       = srcA - srcB;
  assign sub_no_borrow = (srcA >= srcB);
  assign prod          = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};
  assign div_zero      = (srcB == '0);

`ifdef ALU_SHIFT_EN
  logic [WIDTH:0] sll_ext;
  logic [WIDTH:0] srl_ext;

  // The extra bit catches the last bit shifted out; it stays 0 for a zero shift
  assign sll_ext = {1'b0, srcA} << srcB[4:0];
  assign srl_ext = {srcA, 1'b0} >> srcB[4:0];
`endif

  // Stage p0: operation decode and raw result selection
  always_comb begin
    res_p0 = '0;
    case (alu_ctrl)
      OP_ADD:  res_p0 = add_ext[WIDTH-1:0];
      OP_SUB:  res_p0 = sub_res;
      OP_MUL:  res_p0 = prod[WIDTH-1:0];
      OP_MOV:  res_p0 = srcA;
      OP_DIV:  res_p0 = div_zero ? '1 : (srcA / srcB);
      OP_LNUM: begin
        if (srcB == WIDTH'(1))      res_p0 = {{(WIDTH-8){1'b0}}, srcA[WIDTH-1 -: 8]};
        else if (srcB == WIDTH'(2)) res_p0 = {{(WIDTH-8){1'b0}}, srcA[WIDTH-9 -: 8]};
        else if (srcB == WIDTH'(3)) res_p0 = {{(WIDTH-8){1'b0}}, srcA[WIDTH-17 -: 8]};
        else if (srcB == WIDTH'(4)) res_p0 = {{(WIDTH-8){1'b0}}, srcA[7:0]};
        else                        res_p0 = '0;
      end
`ifdef ALU_SHIFT_EN
      OP_SLL:  res_p0 = sll_ext[WIDTH-1:0];
      OP_SRL:  res_p0 = srl_ext[WIDTH:1];
`endif
      OP_AND:  res_p0 = srcA & srcB;
      OP_OR:   res_p0 = srcA | srcB;
      OP_XOR:  res_p0 = srcA ^ srcB;
      OP_NOT:  res_p0 = ~srcA;
      default: res_p0 = '0;
    endcase
  end

`ifdef ALU_SHIFT_EN
  logic shift_c;
  assign shift_c = (alu_ctrl == OP_SLL) ? sll_ext[WIDTH] : srl_ext[0];
`endif

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .op            (alu_ctrl),
    .a_sign        (srcA[WIDTH-1]),
    .b_sign        (srcB[WIDTH-1]),
    .res           (res_p0),
    .add_carry     (add_ext[WIDTH]),
    .sub_no_borrow (sub_no_borrow),
    .mul_hi        (prod[2*WIDTH-1:WIDTH]),
    .div_zero      (div_zero),
`ifdef ALU_SHIFT_EN
    .shift_c       (shift_c),
`endif
    .flags         (flags_p0)
  );

  // Stage p1: output register; reset discards the op presented on that edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_p1 <= '0;
      flags_p1  <= 4'b0000;
    end else begin
      result_p1 <= res_p0;
      flags_p1  <= flags_p0;
    end
  end

  assign result    = result_p1;
  assign alu_flags = flags_p1;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: a vector table plus hand sequences feed a
// scoreboard queue; each result is compared one clock after it is issued.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  alu_ctrl = 5'd0;
  logic [31:0] srcA = 32'd0;
  logic [31:0] srcB = 32'd0;
  logic [31:0] result;
  logic [3:0]  alu_flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t drv_q[$];
  exp_t cap_q[$];
  int   next_id = 0;

  alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_ctrl  (alu_ctrl),
    .srcA      (srcA),
    .srcB      (srcB),
    .result    (result),
    .alu_flags (alu_flags)
  );

  always #5 clk = ~clk;

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input logic [3:0] f);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.f = f;
    vecs.push_back(v);
  endtask

  // Drive one operation just after a rising edge and queue what it must produce
  task automatic apply(input logic rst, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic [3:0] f);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; alu_ctrl = op; srcA = a; srcB = b;
    e.r = r; e.f = f; e.id = next_id;
    next_id++;
    drv_q.push_back(e);
  endtask

  // Independent reference for random ADD/SUB/MUL/XOR/DIV, using wide signed math
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] f);
    logic [63:0] w;
    longint      s;
    logic        c, v;
    c = 1'b0; v = 1'b0; r = 32'd0;
    case (op)
      5'd1: begin
        w = {32'd0, a} + {32'd0, b}; r = w[31:0]; c = w[32];
        s = longint'(int'(a)) + longint'(int'(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd2: begin
        r = a - b; c = (a >= b);
        s = longint'(int'(a)) - longint'(int'(b));
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      5'd3: begin
        w = {32'd0, a} * {32'd0, b}; r = w[31:0]; c = (w[63:32] != 32'd0);
      end
      5'd5: begin
        if (b == 32'd0) begin r = 32'hFFFF_FFFF; v = 1'b1; end
        else r = a / b;
      end
      default: r = a ^ b;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endtask

  // Scoreboard: entries issued before an edge are captured by it and checked
  // on the following falling edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      while (drv_q.size() > 0) cap_q.push_back(drv_q.pop_front());
      @(negedge clk);
      while (cap_q.size() > 0) begin
        e = cap_q.pop_front();
        checks++;
        if (result !== e.r || alu_flags !== e.f) begin
          errors++;
          $display("FAIL op%0d: result=%h flags=%b, expected result=%h flags=%b",
                   e.id, result, alu_flags, e.r, e.f);
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rb, rr;
    logic [3:0]  rf;
    logic [4:0]  rop;

    add_vec(5'd2,  32'd2,          32'd1,         32'd1,          4'b0010);
    add_vec(5'd2,  32'd1,          32'd2,         32'hFFFF_FFFF,  4'b1000);
    add_vec(5'd2,  32'd5,          32'd5,         32'd0,          4'b0110);
    add_vec(5'd2,  32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  4'b0011);
    add_vec(5'd1,  32'h7FFF_FFFF,  32'd1,         32'h8000_0000,  4'b1001);
    add_vec(5'd1,  32'hFFFF_FFFF,  32'd1,         32'd0,          4'b0110);
    add_vec(5'd3,  32'd2,          32'd8,         32'd16,         4'b0000);
    add_vec(5'd3,  32'h0001_0000,  32'h0001_0000, 32'd0,          4'b0110);
    add_vec(5'd3,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,          4'b0010);
    add_vec(5'd5,  32'd16,         32'd4,         32'd4,          4'b0000);
    add_vec(5'd5,  32'd7,          32'd0,         32'hFFFF_FFFF,  4'b1001);
    add_vec(5'd4,  32'h080B_0A02,  32'h1234_5678, 32'h080B_0A02,  4'b0000);
    add_vec(5'd6,  32'h080B_0A02,  32'd1,         32'h08,         4'b0000);
    add_vec(5'd6,  32'h080B_0A02,  32'd2,         32'h0B,         4'b0000);
    add_vec(5'd6,  32'h080B_0A02,  32'd3,         32'h0A,         4'b0000);
    add_vec(5'd6,  32'h080B_0A02,  32'd4,         32'h02,         4'b0000);
    add_vec(5'd6,  32'h080B_0A02,  32'd0,         32'd0,          4'b0100);
    add_vec(5'd6,  32'h080B_0A02,  32'd5,         32'd0,          4'b0100);
    add_vec(5'd9,  32'd1,          32'd1,         32'd1,          4'b0000);
    add_vec(5'd10, 32'd0,          32'd1,         32'd1,          4'b0000);
    add_vec(5'd11, 32'd0,          32'd1,         32'd1,          4'b0000);
    add_vec(5'd12, 32'd0,          32'hDEAD_BEEF, 32'hFFFF_FFFF,  4'b1000);
    add_vec(5'd13, 32'd5,          32'd3,         32'd0,          4'b0000);
    add_vec(5'd31, 32'hFFFF_FFFF,  32'd1,         32'd0,          4'b0000);
    add_vec(5'd0,  32'd9,          32'd9,         32'd0,          4'b0000);
`ifdef ALU_SHIFT_EN
    add_vec(5'd7,  32'd1,          32'd4,         32'd16,         4'b0000);
    add_vec(5'd8,  32'h8000_0001,  32'd1,         32'h4000_0000,  4'b0010);
    add_vec(5'd7,  32'hC000_0000,  32'd1,         32'h8000_0000,  4'b1010);
`else
    add_vec(5'd7,  32'd1,          32'd4,         32'd0,          4'b0000);
    add_vec(5'd8,  32'h8000_0001,  32'd1,         32'd0,          4'b0000);
`endif

    // Reset held for two cycles with an op applied, then first valid result
    apply(1'b0, 5'd1, 32'd1, 32'd5, 32'd0, 4'b0000);
    apply(1'b0, 5'd1, 32'd1, 32'd5, 32'd0, 4'b0000);
    apply(1'b1, 5'd1, 32'd1, 32'd5, 32'd6, 4'b0000);

    // Table vectors, issued back to back
    foreach (vecs[i])
      apply(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].f);

    // Reset mid-stream: op on the reset edge is discarded
    apply(1'b1, 5'd1, 32'd2, 32'd3, 32'd5, 4'b0000);
    apply(1'b0, 5'd3, 32'd3, 32'd3, 32'd0, 4'b0000);
    apply(1'b1, 5'd2, 32'd9, 32'd4, 32'd5, 4'b0010);

    // Random arithmetic against the reference model
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 4))
        0: rop = 5'd1;
        1: rop = 5'd2;
        2: rop = 5'd3;
        3: rop = 5'd5;
        default: rop = 5'd11;
      endcase
      ra = $urandom();
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
      model(rop, ra, rb, rr, rf);
      apply(1'b1, rop, ra, rb, rr, rf);
    end

    // Let the last issued op drain, bounded
    for (int k = 0; k < 6 && (drv_q.size() + cap_q.size()) > 0; k++) @(negedge clk);
    #1;
    if ((drv_q.size() + cap_q.size()) != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", drv_q.size() + cap_q.size());
    end
    if (checks < next_id) begin
      errors++;
      $display("FAIL count: %0d results checked, expected %0d", checks, next_id);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
